// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, baud-counter sizing and the
// parity helper used by both the receiver and the transmitter.
package uart_pkg;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } uart_rx_state_t;

    localparam int PARITY_MAX_BITS = 9;

    function automatic int cnt_width(input int div);
        return (div > 1) ? $clog2(div) : 1;
    endfunction

    // Expected parity bit; callers zero-extend narrower words, which leaves the XOR unchanged.
    function automatic logic calc_parity(input logic [PARITY_MAX_BITS-1:0] data, input logic odd);
        return (^data) ^ odd;
    endfunction

endpackage

// File: rtl/uart_baud_cnt.sv
// Loadable baud down-counter; tick flags the zero count while enabled.
module uart_baud_cnt
    import uart_pkg::*;
#(
    parameter int BAUD_DIV = 2604,
    parameter int CW       = cnt_width(BAUD_DIV)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          load,
    input  logic [CW-1:0] load_val,
    input  logic          en,
    output logic          tick
);

    logic [CW-1:0] cnt_r;

    // Counter register: a load wins, otherwise count toward zero while enabled.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_r <= {CW{1'b0}};
        end else if (load) begin
            cnt_r <= load_val;
        end else if (en && (cnt_r != {CW{1'b0}})) begin
            cnt_r <= cnt_r - {{(CW-1){1'b0}}, 1'b1};
        end else begin
            cnt_r <= cnt_r;
        end
    end

    assign tick = en && (cnt_r == {CW{1'b0}});

endmodule

// File: rtl/uart_rx_param.sv
// Parametrised UART receiver with false-start rejection, parity/framing error
// flags and overrun detection.
module uart_rx_param
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = 8,
    parameter int BAUD_DIV   = 2604,
    parameter int PARITY_EN  = 0,
    parameter int PARITY_ODD = 0,
    parameter int STOP_BITS  = 1
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 RX,
    input  logic                 clr_rdy,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rdy,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 overrun
);

    localparam int            CW        = cnt_width(BAUD_DIV);
    localparam logic [CW-1:0] HALF_LOAD = CW'(BAUD_DIV / 2 - 1);
    localparam logic [CW-1:0] FULL_LOAD = CW'(BAUD_DIV - 1);
    localparam logic [3:0]    LAST_BIT  = 4'(DATA_BITS - 1);
    localparam logic          STOP_LAST = 1'(STOP_BITS - 1);
    localparam logic          ODD_SEL   = 1'(PARITY_ODD);

    logic [1:0]           sync_r;
    logic                 rx_s;
    uart_rx_state_t       state_r, state_nxt_s;
    logic [3:0]           bit_cnt_r, bit_cnt_nxt_s;
    logic [DATA_BITS-1:0] shift_r, shift_nxt_s;
    logic                 par_err_r, par_err_nxt_s;
    logic                 stop_err_r, stop_err_nxt_s;
    logic                 stop_cnt_r, stop_cnt_nxt_s;
    logic [DATA_BITS-1:0] rx_data_r, rx_data_nxt_s;
    logic                 rdy_r, rdy_nxt_s;
    logic                 pe_r, pe_nxt_s;
    logic                 fe_r, fe_nxt_s;
    logic                 ovr_r, ovr_nxt_s;
    logic                 load_s;
    logic [CW-1:0]        load_val_s;
    logic                 tick_s;
    logic                 en_s;

    assign rx_s = sync_r[1];
    assign en_s = (state_r != ST_IDLE);

    uart_baud_cnt #(
        .BAUD_DIV (BAUD_DIV),
        .CW       (CW)
    ) u_baud_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (load_s),
        .load_val (load_val_s),
        .en       (en_s),
        .tick     (tick_s)
    );

    // Two-flop synchroniser for the asynchronous RX pin; idles high.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync_r <= 2'b11;
        end else begin
            sync_r <= {sync_r[0], RX};
        end
    end

    // Frame sequencing and output-register next values.
    always_comb begin
        state_nxt_s    = state_r;
        bit_cnt_nxt_s  = bit_cnt_r;
        shift_nxt_s    = shift_r;
        par_err_nxt_s  = par_err_r;
        stop_err_nxt_s = stop_err_r;
        stop_cnt_nxt_s = stop_cnt_r;
        load_s         = 1'b0;
        load_val_s     = FULL_LOAD;
        rx_data_nxt_s  = rx_data_r;
        pe_nxt_s       = pe_r;
        fe_nxt_s       = fe_r;
        rdy_nxt_s      = rdy_r & ~clr_rdy;
        ovr_nxt_s      = ovr_r & ~clr_rdy;
        case (state_r)
            ST_IDLE: begin
                if (!rx_s) begin
                    load_s      = 1'b1;
                    load_val_s  = HALF_LOAD;
                    state_nxt_s = ST_START;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_START: begin
                if (tick_s && rx_s) begin
                    state_nxt_s = ST_IDLE;
                end else if (tick_s) begin
                    load_s         = 1'b1;
                    bit_cnt_nxt_s  = 4'd0;
                    par_err_nxt_s  = 1'b0;
                    stop_err_nxt_s = 1'b0;
                    stop_cnt_nxt_s = 1'b0;
                    state_nxt_s    = ST_DATA;
                end else begin
                    state_nxt_s = ST_START;
                end
            end
            ST_DATA: begin
                if (tick_s) begin
                    load_s        = 1'b1;
                    shift_nxt_s   = {rx_s, shift_r[DATA_BITS-1:1]};
                    bit_cnt_nxt_s = bit_cnt_r + 4'd1;
                    if (bit_cnt_r == LAST_BIT) begin
                        state_nxt_s = (PARITY_EN != 0) ? ST_PARITY : ST_STOP;
                    end else begin
                        state_nxt_s = ST_DATA;
                    end
                end else begin
                    state_nxt_s = ST_DATA;
                end
            end
            ST_PARITY: begin
                if (tick_s) begin
                    load_s        = 1'b1;
                    par_err_nxt_s = rx_s ^ calc_parity(9'(shift_r), ODD_SEL);
                    state_nxt_s   = ST_STOP;
                end else begin
                    state_nxt_s = ST_PARITY;
                end
            end
            ST_STOP: begin
                if (tick_s && (stop_cnt_r == STOP_LAST)) begin
                    // Completion takes priority over a coincident clr_rdy.
                    rx_data_nxt_s = shift_r;
                    pe_nxt_s      = par_err_r;
                    fe_nxt_s      = stop_err_r | ~rx_s;
                    rdy_nxt_s     = 1'b1;
                    ovr_nxt_s     = (rdy_r | ovr_r) & ~clr_rdy;
                    state_nxt_s   = ST_IDLE;
                end else if (tick_s) begin
                    load_s         = 1'b1;
                    stop_err_nxt_s = stop_err_r | ~rx_s;
                    stop_cnt_nxt_s = 1'b1;
                    state_nxt_s    = ST_STOP;
                end else begin
                    state_nxt_s = ST_STOP;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Receiver state and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r    <= ST_IDLE;
            bit_cnt_r  <= 4'd0;
            shift_r    <= {DATA_BITS{1'b0}};
            par_err_r  <= 1'b0;
            stop_err_r <= 1'b0;
            stop_cnt_r <= 1'b0;
            rx_data_r  <= {DATA_BITS{1'b0}};
            rdy_r      <= 1'b0;
            pe_r       <= 1'b0;
            fe_r       <= 1'b0;
            ovr_r      <= 1'b0;
        end else begin
            state_r    <= state_nxt_s;
            bit_cnt_r  <= bit_cnt_nxt_s;
            shift_r    <= shift_nxt_s;
            par_err_r  <= par_err_nxt_s;
            stop_err_r <= stop_err_nxt_s;
            stop_cnt_r <= stop_cnt_nxt_s;
            rx_data_r  <= rx_data_nxt_s;
            rdy_r      <= rdy_nxt_s;
            pe_r       <= pe_nxt_s;
            fe_r       <= fe_nxt_s;
            ovr_r      <= ovr_nxt_s;
        end
    end

    assign rx_data    = rx_data_r;
    assign rdy        = rdy_r;
    assign parity_err = pe_r;
    assign frame_err  = fe_r;
    assign overrun    = ovr_r;

endmodule
